// File: rtl/capture_frame_buffer_pkg.sv
// Shared types and defaults for the capture frame buffer and its correlator consumer.
// CAPTURE_HOLDOFF_EN adds the post-release holdoff default.
package capture_frame_buffer_pkg;

    localparam int SAMPLE_W           = 16;
    localparam int CORR_WINDOW_WIDTH  = 180;
    localparam int CORR_MAX_DEVIATION = 30;

    // Frame must hold the correlator window plus deviation on both sides.
    localparam int DEF_ADDR_W    = $clog2(CORR_WINDOW_WIDTH + 2 * CORR_MAX_DEVIATION);
    localparam int DEF_PRETRIG   = 64;
    localparam int DEF_THRESHOLD = 2000;
`ifdef CAPTURE_HOLDOFF_EN
    localparam int DEF_HOLDOFF   = 1024;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_FROZEN  = 3'd4,
        ST_HOLDOFF = 3'd5
    } cap_state_e;

    // 17-bit magnitude so that -32768 maps to 32768 rather than overflowing.
    function automatic logic [SAMPLE_W:0] sample_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W:0] ext;
        ext = {s[SAMPLE_W-1], s};
        return s[SAMPLE_W-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/capture_frame_buffer_ram.sv
// capture_ram: DEPTH x 16 sample memory, one synchronous write port, one async read port.
// Contents are not reset.
module capture_ram
    import capture_frame_buffer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [SAMPLE_W-1:0] rd_data_o
);

    logic [SAMPLE_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/capture_frame_buffer.sv
// Records three mic channels into circular RAMs, freezes a pre/post-trigger frame on a
// channel-1 threshold event and serves it to the correlator. Option: CAPTURE_HOLDOFF_EN.
//
// state   | meaning
// IDLE    | one-cycle pass-through after reset or frame release
// FILL    | writing PRETRIG samples of genuine pre-trigger history
// ARMED   | writing, waiting for |sample_1| > THRESHOLD
// POST    | writing the remaining post-trigger samples
// FROZEN  | writes inhibited, frame served to correlator until corr_done
// HOLDOFF | writing but ignoring triggers after a release (optional)
module capture_frame_buffer
    import capture_frame_buffer_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PRETRIG   = DEF_PRETRIG,
    parameter int THRESHOLD = DEF_THRESHOLD
`ifdef CAPTURE_HOLDOFF_EN
   ,parameter int HOLDOFF   = DEF_HOLDOFF
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_1,
    input  logic signed [SAMPLE_W-1:0] sample_2,
    input  logic signed [SAMPLE_W-1:0] sample_3,
    input  logic [ADDR_W-1:0]          rd_addr_ref,
    input  logic [ADDR_W-1:0]          rd_addr_other,
    output logic signed [SAMPLE_W-1:0] rd_data_1,
    output logic signed [SAMPLE_W-1:0] rd_data_2,
    output logic signed [SAMPLE_W-1:0] rd_data_3,
    output logic                       corr_reset,
    output logic                       corr_trigger,
    input  logic                       corr_done,
    output logic                       frame_ready,
    output logic                       overrun,
    output logic [7:0]                 event_count,
    output logic [2:0]                 state
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [SAMPLE_W:0] THR_MAG = (SAMPLE_W+1)'(THRESHOLD);

    cap_state_e        state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic [ADDR_W-1:0] post_cnt_q;
    logic              overrun_q;
    logic [7:0]        event_cnt_q;
    logic              corr_reset_q;
    logic              corr_trigger_q;
    logic              frame_ready_q;

`ifdef CAPTURE_HOLDOFF_EN
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    logic [HO_W-1:0] ho_cnt_q;
    logic            released_q;
`endif

    logic              can_write;
    logic              wr_en;
    logic              over_thr;
    logic [ADDR_W-1:0] rd_idx_ref;
    logic [ADDR_W-1:0] rd_idx_other;
    logic [SAMPLE_W-1:0] rd_raw_1;
    logic [SAMPLE_W-1:0] rd_raw_2;
    logic [SAMPLE_W-1:0] rd_raw_3;

    // The final POST cycle must not write: it would overwrite the oldest frame sample.
    assign can_write = (state_q != ST_FROZEN) && !((state_q == ST_POST) && (post_cnt_q == '0));
    assign wr_en     = sample_valid && can_write;
    assign over_thr  = sample_mag(sample_1) > THR_MAG;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            base_q         <= '0;
            fill_cnt_q     <= '0;
            post_cnt_q     <= '0;
            overrun_q      <= 1'b0;
            event_cnt_q    <= '0;
            corr_reset_q   <= 1'b1;
            corr_trigger_q <= 1'b0;
            frame_ready_q  <= 1'b0;
`ifdef CAPTURE_HOLDOFF_EN
            ho_cnt_q       <= '0;
            released_q     <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (sample_valid && !can_write) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
`ifdef CAPTURE_HOLDOFF_EN
                    if (released_q) begin
                        state_q    <= ST_HOLDOFF;
                        ho_cnt_q   <= HO_W'(HOLDOFF - 1);
                        released_q <= 1'b0;
                    end else begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= ADDR_W'(PRETRIG - 1);
                    end
`else
                    state_q    <= ST_FILL;
                    fill_cnt_q <= ADDR_W'(PRETRIG - 1);
`endif
                end
`ifdef CAPTURE_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (wr_en) begin
                        if (ho_cnt_q == '0) begin
                            state_q    <= ST_FILL;
                            fill_cnt_q <= ADDR_W'(PRETRIG - 1);
                        end else begin
                            ho_cnt_q <= ho_cnt_q - 1'b1;
                        end
                    end
                end
`endif
                ST_FILL: begin
                    if (wr_en) begin
                        if (fill_cnt_q == '0) begin
                            state_q <= ST_ARMED;
                        end else begin
                            fill_cnt_q <= fill_cnt_q - 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (wr_en && over_thr) begin
                        state_q    <= ST_POST;
                        post_cnt_q <= ADDR_W'(DEPTH - PRETRIG - 1);
                    end
                end
                ST_POST: begin
                    // Last write already left wr_ptr on the oldest frame sample.
                    if (post_cnt_q == '0) begin
                        state_q        <= ST_FROZEN;
                        base_q         <= wr_ptr_q;
                        corr_reset_q   <= 1'b0;
                        corr_trigger_q <= 1'b1;
                        frame_ready_q  <= 1'b1;
                    end else if (wr_en) begin
                        post_cnt_q <= post_cnt_q - 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (corr_done) begin
                        state_q        <= ST_IDLE;
                        event_cnt_q    <= event_cnt_q + 1'b1;
                        corr_reset_q   <= 1'b1;
                        corr_trigger_q <= 1'b0;
                        frame_ready_q  <= 1'b0;
`ifdef CAPTURE_HOLDOFF_EN
                        released_q     <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_idx_ref   = base_q + rd_addr_ref;
    assign rd_idx_other = base_q + rd_addr_other;

    capture_ram #(.ADDR_W(ADDR_W)) u_ram_1 (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_1),
        .rd_addr_i (rd_idx_ref),
        .rd_data_o (rd_raw_1)
    );

    capture_ram #(.ADDR_W(ADDR_W)) u_ram_2 (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_2),
        .rd_addr_i (rd_idx_other),
        .rd_data_o (rd_raw_2)
    );

    capture_ram #(.ADDR_W(ADDR_W)) u_ram_3 (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_3),
        .rd_addr_i (rd_idx_other),
        .rd_data_o (rd_raw_3)
    );

    assign rd_data_1    = rd_raw_1;
    assign rd_data_2    = rd_raw_2;
    assign rd_data_3    = rd_raw_3;
    assign corr_reset   = corr_reset_q;
    assign corr_trigger = corr_trigger_q;
    assign frame_ready  = frame_ready_q;
    assign overrun      = overrun_q;
    assign event_count  = event_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_capture_frame_buffer.sv
// Randomized bench for capture_frame_buffer; frames are predicted from a sample-history
// model indexed by arrival order (frame = PRETRIG samples before the trigger onwards).
module tb_capture_frame_buffer;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 256;
    localparam int PRETRIG = 64;
    localparam int THR     = 2000;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic signed [15:0] sample_1, sample_2, sample_3;
    logic [ADDR_W-1:0] rd_addr_ref, rd_addr_other;
    logic signed [15:0] rd_data_1, rd_data_2, rd_data_3;
    logic              corr_reset, corr_trigger, corr_done;
    logic              frame_ready, overrun;
    logic [7:0]        event_count;
    logic [2:0]        state;

    always #5 clk = ~clk;

    capture_frame_buffer #(.ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .THRESHOLD(THR)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_1      (sample_1),
        .sample_2      (sample_2),
        .sample_3      (sample_3),
        .rd_addr_ref   (rd_addr_ref),
        .rd_addr_other (rd_addr_other),
        .rd_data_1     (rd_data_1),
        .rd_data_2     (rd_data_2),
        .rd_data_3     (rd_data_3),
        .corr_reset    (corr_reset),
        .corr_trigger  (corr_trigger),
        .corr_done     (corr_done),
        .frame_ready   (frame_ready),
        .overrun       (overrun),
        .event_count   (event_count),
        .state         (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: every sample accepted since the current frame started.
    int h1[$], h2[$], h3[$];
    int trig_i;
    bit m_frozen;
    bit m_overrun;
    int m_events;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int rand16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int rand_quiet();
        return int'($urandom_range(0, 2 * THR)) - THR;
    endfunction

    function automatic int rand_armed();
        case ($urandom_range(0, 15))
            0: return 2001;
            1: return -2001;
            2: return -32768;
            3: return 32767;
            4: return 2000;
            5: return -2000;
            default: return rand_quiet();
        endcase
    endfunction

    task automatic model_clear();
        h1.delete(); h2.delete(); h3.delete();
        trig_i   = -1;
        m_frozen = 1'b0;
    endtask

    // One strobe followed by an idle cycle; the model records what the buffer should keep.
    task automatic send(input int a, input int b, input int c);
        int idx;
        sample_valid = 1'b1;
        sample_1 = a[15:0];
        sample_2 = b[15:0];
        sample_3 = c[15:0];
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        if (m_frozen) begin
            m_overrun = 1'b1;
        end else begin
            h1.push_back(a); h2.push_back(b); h3.push_back(c);
            idx = h1.size() - 1;
            if (trig_i < 0 && idx >= PRETRIG && iabs(a) > THR) trig_i = idx;
            if (trig_i >= 0 && (idx - trig_i + 1) == DEPTH - PRETRIG) m_frozen = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        corr_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_overrun = 1'b0;
        m_events  = 0;
        model_clear();
    endtask

    task automatic start_frame();
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic check_frozen(input string tag);
        check({tag, "_state"}, int'(state), 4);
        check({tag, "_ready"}, int'(frame_ready), 1);
        check({tag, "_creset"}, int'(corr_reset), 0);
        check({tag, "_ctrig"}, int'(corr_trigger), 1);
        check({tag, "_overrun"}, int'(overrun), int'(m_overrun));
        check({tag, "_events"}, int'(event_count), m_events);
    endtask

    task automatic check_frame(input int n);
        int start, r, o;
        start = (trig_i < 0) ? 0 : trig_i - PRETRIG;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r = (i == 0) ? 0 : (i == 1) ? DEPTH - 1 : (i == 2) ? PRETRIG : int'($urandom_range(0, DEPTH - 1));
            o = (i == 0) ? DEPTH - 1 : (i == 1) ? 0 : int'($urandom_range(0, DEPTH - 1));
            rd_addr_ref   = r[ADDR_W-1:0];
            rd_addr_other = o[ADDR_W-1:0];
            #1;
            if (start + DEPTH <= h1.size()) begin
                check("rd1", int'(rd_data_1), h1[start + r]);
                check("rd2", int'(rd_data_2), h2[start + o]);
                check("rd3", int'(rd_data_3), h3[start + o]);
            end else begin
                check("frame_len", h1.size(), start + DEPTH);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic release_frame();
        corr_done = 1'b1;
        @(posedge clk); #1;
        corr_done = 1'b0;
        m_events++;
        check("rel_state", int'(state), 0);
        check("rel_events", int'(event_count), m_events);
        check("rel_creset", int'(corr_reset), 1);
        check("rel_ctrig", int'(corr_trigger), 0);
        check("rel_ready", int'(frame_ready), 0);
    endtask

    task automatic rand_frame();
        int n, a;
        start_frame();
        n = 0;
        while (!m_frozen && n < 2000) begin
            if (h1.size() < PRETRIG)         a = rand_quiet();
            else if (trig_i < 0 && n > 400)  a = 5000;
            else                             a = rand_armed();
            send(a, rand16(), rand16());
            n++;
        end
        check_frozen("rnd");
        check_frame(12);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) send(rand16(), rand16(), rand16());
        check("rnd_overrun2", int'(overrun), int'(m_overrun));
        check_frame(4);
        release_frame();
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; corr_done = 1'b0;
        sample_1 = '0; sample_2 = '0; sample_3 = '0;
        rd_addr_ref = '0; rd_addr_other = '0;
        m_overrun = 1'b0; m_events = 0; model_clear();
        @(posedge clk); #1;
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_events", int'(event_count), 0);
        check("rst_creset", int'(corr_reset), 1);
        check("rst_ctrig", int'(corr_trigger), 0);
        check("rst_ready", int'(frame_ready), 0);

        // Pre-trigger fill then a just-over-threshold trigger.
        start_frame();
        for (int i = 0; i < PRETRIG - 1; i++) send(0, rand16(), rand16());
        check("fill_state", int'(state), 1);
        send(0, rand16(), rand16());
        check("armed_at_64", int'(state), 2);
        send(2001, rand16(), rand16());
        check("post_state", int'(state), 3);
        for (int i = 0; i < DEPTH - PRETRIG - 1; i++) send(rand16(), rand16(), rand16());
        check_frozen("t1");
        check_frame(16);

        // Strobes while frozen are dropped and flag overrun.
        for (int i = 0; i < 4; i++) send(rand16(), rand16(), rand16());
        check_frozen("ovr");
        check_frame(16);
        release_frame();
        corr_done = 1'b1;
        @(posedge clk); #1;
        corr_done = 1'b0;
        check("done_ignored_events", int'(event_count), m_events);
        check("done_ignored_state", int'(state), 1);

        // Threshold equality and sign handling.
        start_frame();
        for (int i = 0; i < PRETRIG; i++) send(rand_quiet(), rand16(), rand16());
        send(2000, rand16(), rand16());
        check("eq_pos_no_trig", int'(state), 2);
        send(-2000, rand16(), rand16());
        check("eq_neg_no_trig", int'(state), 2);
        send(-2001, rand16(), rand16());
        check("neg_trig", int'(state), 3);
        for (int i = 0; i < DEPTH - PRETRIG - 1; i++) send(rand16(), rand16(), rand16());
        check_frozen("thr");
        @(negedge clk);
        rd_addr_ref = 8'd64;
        #1;
        check("trig_sample_addr64", int'(rd_data_1), -2001);
        check_frame(8);
        release_frame();

        // Ramp with trigger at index 300: frame base wraps around the RAM.
        do_reset();
        start_frame();
        for (int i = 0; i < 492; i++) send((i == 300) ? 5000 : i, i, i);
        check_frozen("ramp");
        @(negedge clk);
        rd_addr_ref = 8'd0;
        rd_addr_other = 8'd255;
        #1;
        check("ramp_ref0", int'(rd_data_1), 236);
        check("ramp_oth255_ch2", int'(rd_data_2), 491);
        check("ramp_oth255_ch3", int'(rd_data_3), 491);
        check_frame(8);
        send(1, 2, 3);
        check("ramp_overrun", int'(overrun), 1);
        release_frame();

        // Reset in the middle of POST abandons the frame.
        start_frame();
        for (int i = 0; i < PRETRIG; i++) send(rand_quiet(), rand16(), rand16());
        send(-32768, rand16(), rand16());
        for (int i = 0; i < 50; i++) send(rand16(), rand16(), rand16());
        check("midpost_state", int'(state), 3);
        do_reset();
        check("midpost_rst_state", int'(state), 0);
        check("midpost_rst_overrun", int'(overrun), 0);
        check("midpost_rst_events", int'(event_count), 0);

        for (int f = 0; f < 8; f++) rand_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
